// File: rtl/mod_exp_pkg.sv
// Shared types for the modular exponentiation engine and its modmul datapath.
// Also holds the closed-form latency so callers can budget the engine's timing.
package mod_exp_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StReduce,
    StSquare,
    StMult,
    StDone
  } exp_state_e;

  typedef enum logic {
    MmLoad,
    MmIter
  } mm_state_e;

  // Cycles from the start-acceptance edge to the edge that raises done.
  function automatic int unsigned exp_latency(input int unsigned mod_width,
                                              input int unsigned exp_width,
                                              input int unsigned popcnt,
                                              input bit          const_time,
                                              input bit          degenerate);
    int unsigned l;
    l = mod_width + 1;
    if (degenerate) return 2;
    if (const_time) return l * (1 + 2 * exp_width) + 2;
    return l * (1 + exp_width + popcnt) + 2;
  endfunction

endpackage

// File: rtl/mod_mul_interleaved.sv
// Interleaved shift-add modular multiplier: p = a*b mod m, fixed WIDTH+1 cycle latency.
// ready and p are combinational during the last iteration so the caller can chain operations.
module mod_mul_interleaved
  import mod_exp_pkg::*;
#(
  parameter int unsigned WIDTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic             ready,
  output logic [WIDTH-1:0] p
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mm_state_e        r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_r;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] w_next;

  // r < m on entry, so 2r+b < 3m fits in WIDTH+2 bits and two subtractions restore r < m.
  function automatic logic [WIDTH-1:0] iter_step(input logic [WIDTH-1:0] r,
                                                 input logic             add,
                                                 input logic [WIDTH-1:0] bb,
                                                 input logic [WIDTH-1:0] mm);
    logic [WIDTH+1:0] t;
    logic [WIDTH+1:0] mx;
    mx = {2'b00, mm};
    t  = {2'b00, r} << 1;
    if (add) t = t + {2'b00, bb};
    if (t >= mx) t = t - mx;
    if (t >= mx) t = t - mx;
    return t[WIDTH-1:0];
  endfunction

  always_comb begin
    w_next = iter_step(r_r, r_a[r_cnt], r_b, r_m);
  end

  assign ready = (r_state == MmIter) && (r_cnt == '0);
  assign p     = w_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= MmLoad;
      r_a     <= '0;
      r_b     <= '0;
      r_m     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        MmLoad: begin
          if (go) begin
            r_a     <= a;
            r_b     <= b;
            r_m     <= m;
            r_r     <= '0;
            r_cnt   <= CntW'(WIDTH - 1);
            r_state <= MmIter;
          end
        end
        MmIter: begin
          r_r <= w_next;
          if (r_cnt == '0) r_state <= MmLoad;
          else r_cnt <= r_cnt - 1'b1;
        end
        default: r_state <= MmLoad;
      endcase
    end
  end

endmodule

// File: rtl/mod_exp_param.sv
// Sequential left-to-right modular exponentiation: result = base^exponent mod modulus.
// One time-shared modmul serves the base reduction, every square and every multiply.
module mod_exp_param
  import mod_exp_pkg::*;
#(
  parameter int unsigned MOD_WIDTH  = 256,
  parameter int unsigned EXP_WIDTH  = 256,
  parameter bit          CONST_TIME = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [MOD_WIDTH-1:0] base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [MOD_WIDTH-1:0] modulus,
  output logic                 busy,
  output logic                 done,
  output logic [MOD_WIDTH-1:0] result,
  output logic                 error
);

  localparam int unsigned IdxW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  exp_state_e           r_state;
  logic [MOD_WIDTH-1:0] r_base;
  logic [EXP_WIDTH-1:0] r_exp;
  logic [MOD_WIDTH-1:0] r_mod;
  logic [MOD_WIDTH-1:0] r_acc;
  logic [MOD_WIDTH-1:0] r_bred;
  logic [IdxW-1:0]      r_idx;
  logic                 r_go;
  logic                 r_busy;
  logic                 r_done;
  logic [MOD_WIDTH-1:0] r_result;
  logic                 r_error;

  logic [MOD_WIDTH-1:0] w_mm_a;
  logic [MOD_WIDTH-1:0] w_mm_b;
  logic                 w_mm_ready;
  logic [MOD_WIDTH-1:0] w_mm_p;
  logic                 w_bit;
  logic                 w_last;

  // Operand routing for the shared multiplier; reduction is base*1 mod m.
  always_comb begin
    w_mm_a = r_acc;
    w_mm_b = r_acc;
    case (r_state)
      StReduce: begin
        w_mm_a = r_base;
        w_mm_b = MOD_WIDTH'(1);
      end
      StMult:  w_mm_b = r_bred;
      default: ;
    endcase
  end

  assign w_bit  = r_exp[r_idx];
  assign w_last = (r_idx == '0);

  mod_mul_interleaved #(
    .WIDTH(MOD_WIDTH)
  ) u_mm (
    .clk  (clk),
    .reset(reset),
    .go   (r_go),
    .a    (w_mm_a),
    .b    (w_mm_b),
    .m    (r_mod),
    .ready(w_mm_ready),
    .p    (w_mm_p)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_base   <= '0;
      r_exp    <= '0;
      r_mod    <= '0;
      r_acc    <= '0;
      r_bred   <= '0;
      r_idx    <= '0;
      r_go     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_error  <= 1'b0;
    end else begin
      r_go   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_base  <= base;
            r_exp   <= exponent;
            r_mod   <= modulus;
            r_busy  <= 1'b1;
            r_error <= 1'b0;
            r_state <= StCheck;
          end
        end
        StCheck: begin
          if (r_mod == '0) begin
            r_error <= 1'b1;
            r_acc   <= '0;
            r_state <= StDone;
          end else if (r_mod == MOD_WIDTH'(1)) begin
            r_acc   <= '0;
            r_state <= StDone;
          end else begin
            r_go    <= 1'b1;
            r_state <= StReduce;
          end
        end
        StReduce: begin
          if (w_mm_ready) begin
            r_bred  <= w_mm_p;
            r_acc   <= MOD_WIDTH'(1);
            r_idx   <= IdxW'(EXP_WIDTH - 1);
            r_go    <= 1'b1;
            r_state <= StSquare;
          end
        end
        StSquare: begin
          // Bit advance is folded into the op's final cycle so it costs nothing extra.
          if (w_mm_ready) begin
            r_acc <= w_mm_p;
            if (w_bit || CONST_TIME) begin
              r_go    <= 1'b1;
              r_state <= StMult;
            end else if (w_last) begin
              r_state <= StDone;
            end else begin
              r_idx <= r_idx - 1'b1;
              r_go  <= 1'b1;
            end
          end
        end
        StMult: begin
          if (w_mm_ready) begin
            if (w_bit) r_acc <= w_mm_p;
            if (w_last) begin
              r_state <= StDone;
            end else begin
              r_idx   <= r_idx - 1'b1;
              r_go    <= 1'b1;
              r_state <= StSquare;
            end
          end
        end
        StDone: begin
          r_result <= r_acc;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign error  = r_error;

endmodule

// File: tb/tb_mod_exp_param.sv
// Scoreboard bench for mod_exp_param: small variable-time and constant-time engines plus a
// wide engine for an RSA encrypt/decrypt round trip.
module tb_mod_exp_param;
  import mod_exp_pkg::*;

  localparam int unsigned MW = 16;
  localparam int unsigned EW = 8;
  localparam int unsigned BW = 128;

  typedef struct {
    logic [BW-1:0] res;
    logic          err;
    int unsigned   lat;
    int unsigned   t0;
    string         name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          start_a, start_b, start_c;
  logic [MW-1:0] base_s, mod_s;
  logic [EW-1:0] exp_s;
  logic [BW-1:0] base_w, exp_w, mod_w;

  logic          busy_a, done_a, err_a;
  logic          busy_b, done_b, err_b;
  logic          busy_c, done_c, err_c;
  logic [MW-1:0] res_a, res_b;
  logic [BW-1:0] res_c;

  exp_t q_a[$], q_b[$], q_c[$];
  exp_t it_a, it_b, it_c;

  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  mod_exp_param #(.MOD_WIDTH(MW), .EXP_WIDTH(EW), .CONST_TIME(1'b0)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .base(base_s), .exponent(exp_s),
    .modulus(mod_s), .busy(busy_a), .done(done_a), .result(res_a), .error(err_a)
  );

  mod_exp_param #(.MOD_WIDTH(MW), .EXP_WIDTH(EW), .CONST_TIME(1'b1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .base(base_s), .exponent(exp_s),
    .modulus(mod_s), .busy(busy_b), .done(done_b), .result(res_b), .error(err_b)
  );

  mod_exp_param #(.MOD_WIDTH(BW), .EXP_WIDTH(BW), .CONST_TIME(1'b0)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .base(base_w), .exponent(exp_w),
    .modulus(mod_w), .busy(busy_c), .done(done_c), .result(res_c), .error(err_c)
  );

  task automatic compare(input exp_t e, input logic [BW-1:0] r, input logic er);
    int unsigned lat;
    lat = cyc - e.t0;
    if (r !== e.res) begin
      n_err++;
      $display("FAIL %s result: got %0h expected %0h", e.name, r, e.res);
    end
    if (er !== e.err) begin
      n_err++;
      $display("FAIL %s error: got %0b expected %0b", e.name, er, e.err);
    end
    if (lat != e.lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d expected %0d", e.name, lat, e.lat);
    end
  endtask

  // Monitors: pop and compare on every done pulse.
  always @(negedge clk) begin
    if (done_a) begin
      if (busy_a) begin n_err++; $display("FAIL a busy_with_done: got 1 expected 0"); end
      if (q_a.size() == 0) begin
        n_err++; $display("FAIL a spurious_done: got done=1 expected none");
      end else begin
        it_a = q_a.pop_front();
        compare(it_a, {{(BW-MW){1'b0}}, res_a}, err_a);
      end
    end
  end

  always @(negedge clk) begin
    if (done_b) begin
      if (busy_b) begin n_err++; $display("FAIL b busy_with_done: got 1 expected 0"); end
      if (q_b.size() == 0) begin
        n_err++; $display("FAIL b spurious_done: got done=1 expected none");
      end else begin
        it_b = q_b.pop_front();
        compare(it_b, {{(BW-MW){1'b0}}, res_b}, err_b);
      end
    end
  end

  always @(negedge clk) begin
    if (done_c) begin
      if (busy_c) begin n_err++; $display("FAIL c busy_with_done: got 1 expected 0"); end
      if (q_c.size() == 0) begin
        n_err++; $display("FAIL c spurious_done: got done=1 expected none");
      end else begin
        it_c = q_c.pop_front();
        compare(it_c, res_c, err_c);
      end
    end
  end

  function automatic int qsize(input int d);
    if (d == 0) return q_a.size();
    if (d == 1) return q_b.size();
    return q_c.size();
  endfunction

  task automatic issue(input int d, input logic [BW-1:0] b, input logic [BW-1:0] e,
                       input logic [BW-1:0] m, input logic [BW-1:0] xres, input logic xerr,
                       input int unsigned xlat, input string nm);
    exp_t it;
    @(negedge clk);
    base_s = b[MW-1:0];
    exp_s  = e[EW-1:0];
    mod_s  = m[MW-1:0];
    base_w = b;
    exp_w  = e;
    mod_w  = m;
    if (d == 0) start_a = 1'b1;
    else if (d == 1) start_b = 1'b1;
    else start_c = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    it.res  = xres;
    it.err  = xerr;
    it.lat  = xlat;
    it.t0   = cyc;
    it.name = nm;
    if (d == 0) q_a.push_back(it);
    else if (d == 1) q_b.push_back(it);
    else q_c.push_back(it);
    n_vec++;
  endtask

  task automatic wait_idle(input int d, input int unsigned bound);
    int unsigned n;
    n = 0;
    while (qsize(d) != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (qsize(d) != 0) begin
      n_err++;
      $display("FAIL timeout dut%0d: got no done within %0d cycles", d, bound);
      if (d == 0) q_a.delete();
      else if (d == 1) q_b.delete();
      else q_c.delete();
    end
  endtask

  function automatic logic [BW-1:0] model_modexp(input logic [BW-1:0] b, input logic [BW-1:0] e,
                                                 input logic [BW-1:0] m);
    logic [2*BW-1:0] r, x, mm;
    mm = {{BW{1'b0}}, m};
    r  = 1;
    x  = {{BW{1'b0}}, b} % mm;
    for (int i = 0; i < int'(BW); i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r[BW-1:0];
  endfunction

  function automatic logic [BW-1:0] mod_inv(input logic [BW-1:0] a, input logic [BW-1:0] n);
    logic [2*BW-1:0] old_r, r, tmp, qt, old_t, t, prod, nn;
    nn    = {{BW{1'b0}}, n};
    old_r = nn;
    r     = {{BW{1'b0}}, a};
    old_t = '0;
    t     = 1;
    while (r != 0) begin
      qt    = old_r / r;
      tmp   = old_r - qt * r;
      old_r = r;
      r     = tmp;
      prod  = (qt * t) % nn;
      tmp   = (old_t >= prod) ? old_t - prod : old_t + nn - prod;
      old_t = t;
      t     = tmp;
    end
    return old_t[BW-1:0];
  endfunction

  initial begin
    logic [63:0]   p, q;
    logic [BW-1:0] n, phi, e, d, msg, ct;
    int unsigned   drops, waited;

    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    base_s = '0; exp_s = '0; mod_s = '0;
    base_w = '0; exp_w = '0; mod_w = '0;
    reset = 1'b1;
    #1;
    if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    if (done_a !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done_a); end
    if (res_a !== '0) begin n_err++; $display("FAIL reset_result: got %0h expected 0", res_a); end
    if (err_a !== 1'b0) begin n_err++; $display("FAIL reset_error: got %b expected 0", err_a); end
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Variable-time engine, hand-computed results and latencies (L = 17).
    issue(0, 4, 13, 497, 445, 1'b0, 206, "pow_4_13_497");         wait_idle(0, 400);
    issue(0, 1000, 3, 7, 6, 1'b0, 189, "pow_1000_3_7");           wait_idle(0, 400);
    issue(0, 3, 0, 7, 1, 1'b0, 155, "pow_3_0_7");                 wait_idle(0, 400);
    issue(0, 0, 5, 11, 0, 1'b0, 189, "pow_0_5_11");               wait_idle(0, 400);
    issue(0, 5, 3, 0, 0, 1'b1, 2, "mod_zero");                    wait_idle(0, 20);
    issue(0, 5, 9, 1, 0, 1'b0, 2, "mod_one");                     wait_idle(0, 20);

    // Constant-time engine: fixed 17*17+2 cycles.
    issue(1, 4, 13, 497, 445, 1'b0, 291, "ct_pow_4_13_497");      wait_idle(1, 600);
    issue(1, 1000, 3, 7, 6, 1'b0, 291, "ct_pow_1000_3_7");        wait_idle(1, 600);

    // A second start mid-operation must be ignored.
    issue(0, 4, 13, 497, 445, 1'b0, 206, "ignore_start");
    repeat (49) @(negedge clk);
    base_s = 7; exp_s = 200; mod_s = 11; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    drops = 0;
    waited = 0;
    while (q_a.size() != 0 && waited < 400) begin
      if (!busy_a && !done_a) drops++;
      @(negedge clk);
      waited++;
    end
    if (drops != 0) begin n_err++; $display("FAIL busy_held: got %0d low cycles expected 0", drops); end
    wait_idle(0, 10);

    // Reset mid-operation aborts with no done.
    issue(0, 5, 200, 1009, 0, 1'b0, 0, "aborted");
    repeat (99) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    q_a.delete();
    if (busy_a !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy_a); end
    if (done_a !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b expected 0", done_a); end
    if (res_a !== '0) begin n_err++; $display("FAIL abort_result: got %0h expected 0", res_a); end
    if (err_a !== 1'b0) begin n_err++; $display("FAIL abort_error: got %b expected 0", err_a); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    issue(0, 4, 13, 497, 445, 1'b0, 206, "after_reset");          wait_idle(0, 400);

    // RSA round trip on the wide engine.
    p   = 64'd8475698667747010771;
    q   = 64'd11297384090418420749;
    n   = {64'b0, p} * {64'b0, q};
    phi = ({64'b0, p} - BW'(1)) * ({64'b0, q} - BW'(1));
    e   = BW'(65537);
    d   = mod_inv(e, phi);
    msg = 128'h0e3f7795eb00000000;
    ct  = model_modexp(msg, e, n);
    issue(2, msg, e, n, ct, 1'b0,
          exp_latency(BW, BW, int'($countones(e)), 1'b0, 1'b0), "rsa_encrypt");
    wait_idle(2, 40000);
    issue(2, ct, d, n, msg, 1'b0,
          exp_latency(BW, BW, int'($countones(d)), 1'b0, 1'b0), "rsa_decrypt");
    wait_idle(2, 40000);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
